// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INST   = 32'h0000_0013;
  localparam logic [31:0] WORD_BYTES = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// First-word-fall-through buffer of fetched {pc, inst} pairs with synchronous flush.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         enq,
  input  fetch_entry_t                 enq_entry,
  input  logic                         deq,
  output fetch_entry_t                 head,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             full;
  logic             do_enq;
  logic             do_deq;

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign do_deq = deq && !empty;
  // A write into a full buffer is only legal when the head leaves in the same cycle.
  assign do_enq = enq && (!full || do_deq);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + 1'b1;
      if (do_deq) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_enq) - CNT_W'(do_deq);
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq) mem[wr_ptr] <= enq_entry;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited imem requests, in-flight tracking, FWFT buffer.
// Optional FETCH_STATS_EN adds dequeued/squashed instruction counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          IMEM_LATENCY = 2,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic [31:0] imem_data_in,
  input  logic        redirect_valid_in,
  input  logic [31:0] redirect_pc_in,
  output logic        inst_valid_out,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  input  logic        inst_ready_in
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] fetched_count_out,
  output logic [31:0] squashed_count_out
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [31:0]             fetch_pc;
  logic [IMEM_LATENCY-1:0] inflight_vld_p;
  logic [31:0]             inflight_pc_p [IMEM_LATENCY];
  logic [CNT_W-1:0]        fifo_count;
  logic                    fifo_empty;
  fetch_entry_t            enq_entry;
  fetch_entry_t            head;
  logic                    enq;
  logic                    deq;
  logic                    issue;
  logic [31:0]             occ;

  assign enq       = inflight_vld_p[IMEM_LATENCY-1];
  assign deq       = inst_valid_out && inst_ready_in && !redirect_valid_in;
  assign enq_entry = '{pc: inflight_pc_p[IMEM_LATENCY-1], inst: imem_data_in};

  // Everything already owed a FIFO slot: buffered, in flight, and this cycle's request.
  always_comb begin
    occ = 32'(fifo_count) + 32'(imem_req_out);
    for (int i = 0; i < IMEM_LATENCY; i++) occ = occ + 32'(inflight_vld_p[i]);
  end

  assign issue = (occ - 32'(deq)) < 32'(FIFO_DEPTH);

  // Request stage and in-flight slot shift (slot IMEM_LATENCY-1 meets returning data)
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      imem_req_out   <= 1'b0;
      imem_addr_out  <= RESET_PC;
      fetch_pc       <= RESET_PC;
      inflight_vld_p <= '0;
    end else if (redirect_valid_in) begin
      imem_req_out   <= 1'b1;
      imem_addr_out  <= align_pc(redirect_pc_in);
      fetch_pc       <= align_pc(redirect_pc_in) + WORD_BYTES;
      inflight_vld_p <= '0;
    end else begin
      imem_req_out <= issue;
      if (issue) begin
        imem_addr_out <= fetch_pc;
        fetch_pc      <= fetch_pc + WORD_BYTES;
      end
      inflight_vld_p[0] <= imem_req_out;
      for (int i = 1; i < IMEM_LATENCY; i++) inflight_vld_p[i] <= inflight_vld_p[i-1];
    end
  end

  always_ff @(posedge clk_in) begin
    inflight_pc_p[0] <= imem_addr_out;
    for (int i = 1; i < IMEM_LATENCY; i++) inflight_pc_p[i] <= inflight_pc_p[i-1];
  end

  // Buffer stage
  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk_in),
    .rst      (rst_in),
    .flush    (redirect_valid_in),
    .enq      (enq),
    .enq_entry(enq_entry),
    .deq      (deq),
    .head     (head),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign inst_valid_out = !fifo_empty;
  assign inst_out       = fifo_empty ? NOP_INST : head.inst;
  assign pc_out         = fifo_empty ? RESET_PC : head.pc;

`ifdef FETCH_STATS_EN
  // A redirect kills exactly what the credit count was holding.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      fetched_count_out  <= '0;
      squashed_count_out <= '0;
    end else begin
      if (deq) fetched_count_out <= fetched_count_out + 32'd1;
      if (redirect_valid_in) squashed_count_out <= squashed_count_out + occ;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an address-encoding imem model and a PC scoreboard.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          LAT    = 2;
  localparam int          DEPTH  = 4;

  logic        clk_in;
  logic        rst_in;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic [31:0] imem_data_in;
  logic        redirect_valid_in;
  logic [31:0] redirect_pc_in;
  logic        inst_valid_out;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        inst_ready_in;
`ifdef FETCH_STATS_EN
  logic [31:0] fetched_count_out;
  logic [31:0] squashed_count_out;
`endif

  fetch_unit #(
    .RESET_PC    (RST_PC),
    .IMEM_LATENCY(LAT),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .imem_req_out     (imem_req_out),
    .imem_addr_out    (imem_addr_out),
    .imem_data_in     (imem_data_in),
    .redirect_valid_in(redirect_valid_in),
    .redirect_pc_in   (redirect_pc_in),
    .inst_valid_out   (inst_valid_out),
    .inst_out         (inst_out),
    .pc_out           (pc_out),
    .inst_ready_in    (inst_ready_in)
`ifdef FETCH_STATS_EN
    ,
    .fetched_count_out (fetched_count_out),
    .squashed_count_out(squashed_count_out)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  int          req_count = 0;
  int          hs_count = 0;
  logic [31:0] sb [$];

  function automatic logic [31:0] enc(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Memory model: data for a request seen in cycle c is driven for cycle c+LAT.
  logic        hist_vld  [LAT+1];
  logic [31:0] hist_addr [LAT+1];
  initial begin
    for (int k = 0; k <= LAT; k++) begin
      hist_vld[k]  = 1'b0;
      hist_addr[k] = 32'h0;
    end
    imem_data_in = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk_in);
      for (int k = LAT; k > 0; k--) begin
        hist_vld[k]  = hist_vld[k-1];
        hist_addr[k] = hist_addr[k-1];
      end
      hist_vld[0]  = imem_req_out && !rst_in;
      hist_addr[0] = imem_addr_out;
      imem_data_in = hist_vld[LAT] ? enc(hist_addr[LAT]) : 32'hDEAD_BEEF;
    end
  end

  // Output monitor: every accepted word must be the next expected PC.
  initial begin
    logic [31:0] exp_pc;
    forever begin
      @(negedge clk_in);
      if (!rst_in) begin
        if (imem_req_out) req_count++;
        if (inst_valid_out && inst_ready_in && !redirect_valid_in) begin
          hs_count++;
          if (sb.size() == 0) begin
            check("unexpected_output", pc_out, 32'hFFFF_FFFF);
          end else begin
            exp_pc = sb.pop_front();
            check("stream_pc", pc_out, exp_pc);
            check("stream_inst", inst_out, enc(exp_pc));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push_stream(input logic [31:0] start);
    sb.delete();
    for (int k = 0; k < 40; k++) sb.push_back(start + 32'(4 * k));
  endtask

  task automatic release_reset();
    rst_in    = 1'b0;
    req_count = 0;
    hs_count  = 0;
    push_stream(RST_PC);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid_in = 1'b1;
    redirect_pc_in    = pc;
    push_stream(pc & 32'hFFFF_FFFC);
    tick();
    redirect_valid_in = 1'b0;
  endtask

  // Called in cycle r+1 after the final redirect.
  task automatic expect_restart(input logic [31:0] pc);
    check("restart_req", 32'(imem_req_out), 32'd1);
    check("restart_addr", imem_addr_out, pc);
    for (int k = 0; k < 3; k++) begin
      check("restart_gap_valid", 32'(inst_valid_out), 32'd0);
      tick();
    end
    check("restart_valid", 32'(inst_valid_out), 32'd1);
    check("restart_pc", pc_out, pc);
    check("restart_inst", inst_out, enc(pc));
  endtask

  initial begin
    rst_in            = 1'b1;
    redirect_valid_in = 1'b0;
    redirect_pc_in    = 32'h0;
    inst_ready_in     = 1'b1;
    tick();
    tick();

    // Reset release and first stream
    release_reset();
    check("rst_valid", 32'(inst_valid_out), 32'd0);
    check("rst_req", 32'(imem_req_out), 32'd0);
    check("rst_addr", imem_addr_out, RST_PC);
    check("rst_pc", pc_out, RST_PC);
    check("rst_inst", inst_out, NOP_INST);
    tick();
    check("first_req", 32'(imem_req_out), 32'd1);
    check("first_addr", imem_addr_out, RST_PC);
    tick();
    tick();
    check("pre_first_valid", 32'(inst_valid_out), 32'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      check("seq_valid", 32'(inst_valid_out), 32'd1);
      check("seq_pc", pc_out, RST_PC + 32'(4 * k));
      tick();
    end
    tick();

    // Mid-operation reset, then a 10-cycle stall from reset
    rst_in = 1'b1;
    #1;
    check("midrst_valid", 32'(inst_valid_out), 32'd0);
    check("midrst_req", 32'(imem_req_out), 32'd0);
    tick();
    inst_ready_in = 1'b0;
    release_reset();
    for (int k = 0; k < 10; k++) tick();
    check("stall_req_count", 32'(req_count), 32'(DEPTH));
    check("stall_req_idle", 32'(imem_req_out), 32'd0);
    check("stall_head_valid", 32'(inst_valid_out), 32'd1);
    check("stall_head_pc", pc_out, RST_PC);
    inst_ready_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("resume_valid", 32'(inst_valid_out), 32'd1);
      check("resume_pc", pc_out, RST_PC + 32'(4 * k));
      tick();
    end

    // Redirect with words buffered and in flight
    inst_ready_in = 1'b0;
    tick();
    tick();
    inst_ready_in = 1'b1;
    do_redirect(32'h0000_0100);
    expect_restart(32'h0000_0100);
    for (int k = 0; k < 4; k++) tick();

    // Misaligned target
    do_redirect(32'h0000_0203);
    expect_restart(32'h0000_0200);
    for (int k = 0; k < 3; k++) tick();

    // Address wrap
    do_redirect(32'hFFFF_FFF8);
    expect_restart(32'hFFFF_FFF8);
    tick();
    check("wrap_pc_fffc", pc_out, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc_0", pc_out, 32'h0000_0000);
    tick();
    check("wrap_pc_4", pc_out, 32'h0000_0004);
    tick();

    // Redirect during dequeue + return, then three back-to-back redirects
    check("pre_burst_valid", 32'(inst_valid_out), 32'd1);
    do_redirect(32'h0000_0300);
    do_redirect(32'h0000_0400);
    do_redirect(32'h0000_0500);
    expect_restart(32'h0000_0500);
    for (int k = 0; k < 6; k++) tick();

`ifdef FETCH_STATS_EN
    rst_in = 1'b1;
    tick();
    inst_ready_in = 1'b1;
    release_reset();
    begin
      int guard;
      guard = 0;
      while (hs_count < 5 && guard < 50) begin
        tick();
        guard++;
      end
      check("stats_hs_reached", 32'(hs_count), 32'd5);
    end
    inst_ready_in = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    check("stats_fetched", fetched_count_out, 32'd5);
    check("stats_squashed_pre", squashed_count_out, 32'd0);
    do_redirect(32'h0000_0100);
    check("stats_squashed", squashed_count_out, 32'(DEPTH));
    check("stats_fetched_post", fetched_count_out, 32'd5);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
